// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
package seq_det_pkg;

    // Pattern and length loaded into the configuration registers at reset
    localparam logic [31:0] DEFAULT_PAT = 32'b0000_0011;
    localparam int unsigned DEFAULT_LEN = 2;

    // Width of the pattern-length field: wide enough to hold PAT_W and a bit more,
    // so lengths above PAT_W can be requested and clamped.
    function automatic int unsigned len_w(input int unsigned pat_w);
        return $clog2(pat_w) + 1;
    endfunction

    // True when the low 'len' bits of a and b agree; len >= 32 compares everything.
    function automatic logic pat_match(input logic [31:0] a, input logic [31:0] b,
                                       input int unsigned len);
        logic [31:0] mask;
        mask = (len >= 32) ? '1 : ((32'd1 << len) - 32'd1);
        return ((a ^ b) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             sat
);

    // Count state: clear first, then increment unless already at the top.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + 1'b1;
        end
    end

    assign sat = &count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with runtime-loadable pattern, length and overlap mode.
// The match flag is Mealy: it rises in the same cycle as the final pattern bit.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned       PAT_W   = 8,
    parameter int unsigned       CNT_W   = 8,
    parameter logic [PAT_W-1:0]  DEF_PAT = PAT_W'(DEFAULT_PAT),
    parameter int unsigned       DEF_LEN = DEFAULT_LEN,
    localparam int unsigned      LEN_W   = len_w(PAT_W)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             w,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap,
    input  logic             clr_cnt,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    logic [PAT_W-2:0] hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0] cfg_pat_q;
    logic [LEN_W-1:0] cfg_len_q;
    logic             cfg_ovl_q;
    logic [PAT_W-1:0] window;
    int unsigned      eff_len;

    // Newest bit appended below the history; bit 0 of window is w itself.
    assign window = {hist_q, w};

    // Match decode: clamp the length, require enough valid history, compare low L bits.
    always_comb begin
        eff_len = (32'(cfg_len_q) > PAT_W) ? PAT_W : 32'(cfg_len_q);
        out     = 1'b0;
        if (en && !cfg_load && (eff_len >= 1)) begin
            out = (32'(fill_q) >= eff_len - 1) &&
                  pat_match(32'(window), 32'(cfg_pat_q), eff_len);
        end
    end

    // History/fill next state; a non-overlapping match restarts the fill count.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (cfg_load) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = window[PAT_W-2:0];
            if (out && !cfg_ovl_q) begin
                fill_d = '0;
            end else if (32'(fill_q) < PAT_W - 1) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    // History and fill registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

    // Configuration registers: only cfg_load changes them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_pat_q <= DEF_PAT;
            cfg_len_q <= LEN_W'(DEF_LEN);
            cfg_ovl_q <= 1'b1;
        end else if (cfg_load) begin
            cfg_pat_q <= pattern;
            cfg_len_q <= pat_len;
            cfg_ovl_q <= overlap;
        end
    end

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_match_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (clr_cnt),
        .inc  (out),
        .count(match_cnt),
        .sat  (cnt_sat)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param (PAT_W=8, CNT_W=4).
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       w;
    logic       en;
    logic       cfg_load;
    logic [7:0] pattern;
    logic [3:0] pat_len;
    logic       overlap;
    logic       clr_cnt;
    logic       out;
    logic [3:0] match_cnt;
    logic       cnt_sat;

    int vectors = 0;
    int miscompares = 0;

    seq_detector_param #(
        .PAT_W(8),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .w        (w),
        .en       (en),
        .cfg_load (cfg_load),
        .pattern  (pattern),
        .pat_len  (pat_len),
        .overlap  (overlap),
        .clr_cnt  (clr_cnt),
        .out      (out),
        .match_cnt(match_cnt),
        .cnt_sat  (cnt_sat)
    );

    always #5 clk = ~clk;

    // Drive one consumed bit at the falling edge and return the Mealy output.
    task automatic apply_bit(input logic b, output logic o);
        @(negedge clk);
        w = b; en = 1'b1; cfg_load = 1'b0; clr_cnt = 1'b0;
        #1 o = out;
    endtask

    // Present a bit with en low.
    task automatic hold_bit(input logic b, output logic o);
        @(negedge clk);
        w = b; en = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
        #1 o = out;
    endtask

    task automatic idle();
        @(negedge clk);
        en = 1'b0; cfg_load = 1'b0; clr_cnt = 1'b0;
        #1;
    endtask

    task automatic clear_count();
        @(negedge clk);
        en = 1'b0; clr_cnt = 1'b1;
        @(negedge clk);
        clr_cnt = 1'b0;
        #1;
        vectors++;
        if (match_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_cnt: match_cnt=%0d expected 0", match_cnt);
        end
    endtask

    task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic ovl);
        @(negedge clk);
        cfg_load = 1'b1; pattern = p; pat_len = l; overlap = ovl; en = 1'b1; w = 1'b1;
        #1;
        vectors++;
        if (out !== 1'b0) begin
            miscompares++;
            $display("FAIL load_out: out=%b expected 0 during cfg_load", out);
        end
        @(negedge clk);
        cfg_load = 1'b0; en = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; w = 1'b1; en = 1'b1; cfg_load = 1'b0; clr_cnt = 1'b0;
        pattern = 8'h00; pat_len = 4'd0; overlap = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({out, match_cnt, cnt_sat} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_state: out=%b cnt=%0d sat=%b expected 0/0/0",
                     out, match_cnt, cnt_sat);
        end
        @(negedge clk);
        reset = 1'b1; en = 1'b0;
    endtask

    task automatic test_defaults();
        logic [4:0] bits = 5'b01110;
        logic [4:0] exp  = 5'b00110;
        logic o;
        for (int i = 4; i >= 0; i--) begin
            apply_bit(bits[i], o);
            vectors++;
            if (o !== exp[i]) begin
                miscompares++;
                $display("FAIL default_out bit%0d: out=%b expected %b", 5 - i, o, exp[i]);
            end
        end
        idle();
        vectors++;
        if (match_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL default_cnt: match_cnt=%0d expected 2", match_cnt);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001001;
        logic o;
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        clear_count();
        for (int i = 6; i >= 0; i--) begin
            apply_bit(bits[i], o);
            vectors++;
            if (o !== exp[i]) begin
                miscompares++;
                $display("FAIL overlap_out bit%0d: out=%b expected %b", 7 - i, o, exp[i]);
            end
        end
        idle();
        vectors++;
        if (match_cnt !== 4'd2) begin
            miscompares++;
            $display("FAIL overlap_cnt: match_cnt=%0d expected 2", match_cnt);
        end
    endtask

    task automatic test_no_overlap();
        logic [6:0] bits = 7'b1011011;
        logic [6:0] exp  = 7'b0001000;
        logic o;
        load_cfg(8'b0000_1011, 4'd4, 1'b0);
        // Inputs changed without cfg_load must be ignored.
        pattern = 8'hFF; pat_len = 4'd1; overlap = 1'b1;
        clear_count();
        for (int i = 6; i >= 0; i--) begin
            apply_bit(bits[i], o);
            vectors++;
            if (o !== exp[i]) begin
                miscompares++;
                $display("FAIL nonovl_out bit%0d: out=%b expected %b", 7 - i, o, exp[i]);
            end
        end
        idle();
        vectors++;
        if (match_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL nonovl_cnt: match_cnt=%0d expected 1", match_cnt);
        end
    endtask

    task automatic test_enable_hold();
        logic [4:0] hbits = 5'b10101;
        logic [4:0] bits  = 5'b10101;
        logic [4:0] exp   = 5'b00101;
        logic o;
        load_cfg(8'b0000_0101, 4'd3, 1'b1);
        for (int i = 4; i >= 3; i--) begin
            apply_bit(bits[i], o);
            vectors++;
            if (o !== exp[i]) begin
                miscompares++;
                $display("FAIL hold_pre bit%0d: out=%b expected %b", 5 - i, o, exp[i]);
            end
        end
        for (int i = 4; i >= 0; i--) begin
            hold_bit(hbits[i], o);
            vectors++;
            if (o !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_en0 cycle%0d: out=%b expected 0", 5 - i, o);
            end
        end
        for (int i = 2; i >= 0; i--) begin
            apply_bit(bits[i], o);
            vectors++;
            if (o !== exp[i]) begin
                miscompares++;
                $display("FAIL hold_post bit%0d: out=%b expected %b", 5 - i, o, exp[i]);
            end
        end
        idle();
    endtask

    task automatic test_saturation();
        logic o;
        load_cfg(8'b0000_0001, 4'd1, 1'b1);
        clear_count();
        for (int i = 1; i <= 17; i++) begin
            apply_bit(1'b1, o);
            vectors++;
            if (o !== 1'b1) begin
                miscompares++;
                $display("FAIL sat_out cycle%0d: out=%b expected 1", i, o);
            end
            if (i == 15) begin
                vectors++;
                if ({match_cnt, cnt_sat} !== {4'd14, 1'b0}) begin
                    miscompares++;
                    $display("FAIL sat_pre: cnt=%0d sat=%b expected 14/0", match_cnt, cnt_sat);
                end
            end
        end
        idle();
        vectors++;
        if ({match_cnt, cnt_sat} !== {4'd15, 1'b1}) begin
            miscompares++;
            $display("FAIL sat_top: cnt=%0d sat=%b expected 15/1", match_cnt, cnt_sat);
        end
        // Clear coinciding with a match: clear wins.
        @(negedge clk);
        w = 1'b1; en = 1'b1; clr_cnt = 1'b1;
        #1;
        vectors++;
        if (out !== 1'b1) begin
            miscompares++;
            $display("FAIL clr_match_out: out=%b expected 1", out);
        end
        idle();
        vectors++;
        if ({match_cnt, cnt_sat} !== {4'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL clr_priority: cnt=%0d sat=%b expected 0/0", match_cnt, cnt_sat);
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] bits = 4'b1011;
        logic o;
        load_cfg(8'b0000_1011, 4'd4, 1'b1);
        clear_count();
        for (int i = 3; i >= 0; i--) apply_bit(bits[i], o);
        apply_bit(1'b0, o);
        apply_bit(1'b1, o);
        apply_bit(1'b1, o);
        vectors++;
        if (o !== 1'b1 || match_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL pre_reset: out=%b cnt=%0d expected 1/1", o, match_cnt);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if ({out, match_cnt, cnt_sat} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset: out=%b cnt=%0d sat=%b expected 0/0/0",
                     out, match_cnt, cnt_sat);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1; en = 1'b0;
        // Defaults restored (pattern 11, L=2): a lone 1 is only a partial match.
        apply_bit(1'b1, o);
        vectors++;
        if (o !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_partial: out=%b expected 0", o);
        end
        apply_bit(1'b1, o);
        vectors++;
        if (o !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_full: out=%b expected 1", o);
        end
        idle();
    endtask

    task automatic test_length_bounds();
        logic [4:0] zbits = 5'b00010;
        logic [7:0] bits  = 8'b1011_0010;
        logic [7:0] exp   = 8'b0000_0001;
        logic o;
        load_cfg(8'b0000_0000, 4'd0, 1'b1);
        for (int i = 4; i >= 0; i--) begin
            apply_bit(zbits[i], o);
            vectors++;
            if (o !== 1'b0) begin
                miscompares++;
                $display("FAIL len0 bit%0d: out=%b expected 0", 5 - i, o);
            end
        end
        load_cfg(8'b1011_0010, 4'd12, 1'b1);
        for (int i = 7; i >= 0; i--) begin
            apply_bit(bits[i], o);
            vectors++;
            if (o !== exp[i]) begin
                miscompares++;
                $display("FAIL clamp bit%0d: out=%b expected %b", 8 - i, o, exp[i]);
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_overlap();
        test_no_overlap();
        test_enable_hold();
        test_saturation();
        test_async_reset();
        test_length_bounds();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
